// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard scheduler.
package pipeline_stall_ctrl_pkg;

  typedef logic [4:0] reg_id_t;
  typedef logic       bool_t;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MEM_WAIT    = 2'd2
  } stall_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  localparam reg_id_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_fwd_select.sv
// Operand forwarding select for one exec source register.
module pipeline_stall_ctrl_fwd_select
  import pipeline_stall_ctrl_pkg::*;
(
  input  reg_id_t  src_idx,
  input  reg_id_t  ex_rd_idx,
  input  bool_t    ex_reg_write_enable,
  input  bool_t    ex_mem_load_enable,
  input  reg_id_t  mem_rd_idx,
  input  bool_t    mem_reg_write_enable,
  output fwd_sel_t sel
);

  // Newest producer first; a load in exec has no data yet, x0 never forwards.
  always_comb begin
    sel = FWD_REG;
    if (ex_reg_write_enable && !ex_mem_load_enable &&
        ex_rd_idx == src_idx && ex_rd_idx != REG_ZERO) begin
      sel = FWD_EX;
    end else if (mem_reg_write_enable && mem_rd_idx == src_idx &&
                 src_idx != REG_ZERO) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard scheduler: front/exec stall, load-use bubbles, memory wait
// sequencing with sticky timeout, and exec operand forwarding.
//
// state       | meaning
// ------------+-----------------------------------------------------
// RUN         | normal advance; hazards detected here
// LOAD_BUBBLE | extra load-use bubbles still to insert (bub_cnt left)
// MEM_WAIT    | data memory busy; front and exec held
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  dec_rs1_idx,
  input  logic [4:0]  dec_rs2_idx,
  input  logic        dec_uses_rs1,
  input  logic        dec_uses_rs2,
  input  logic [4:0]  ex_rd_idx,
  input  logic        ex_reg_write_enable,
  input  logic        ex_mem_load_enable,
  input  logic [4:0]  mem_rd_idx,
  input  logic        mem_reg_write_enable,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        stall_front,
  output logic        stall_exec,
  output logic        bubble_exec,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        mem_error,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] BUB_RELOAD   = 2'(LOAD_USE_BUBBLES - 1);
  localparam bool_t      MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);
  localparam logic [7:0] TMO          = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TMO_M1       = 8'(MEM_TIMEOUT - 1);

  stall_state_t state;
  logic [1:0]   bub_cnt;
  logic [7:0]   wait_cnt;
  bool_t        mem_wait;
  bool_t        load_use;
  bool_t        front;
  bool_t        exec_hold;
  bool_t        bubble;
  fwd_sel_t     rs1_sel;
  fwd_sel_t     rs2_sel;

  assign mem_wait = mem_access && !mem_ready;
  assign load_use = ex_mem_load_enable && ex_reg_write_enable && (ex_rd_idx != REG_ZERO) &&
                    ((dec_uses_rs1 && dec_rs1_idx == ex_rd_idx) ||
                     (dec_uses_rs2 && dec_rs2_idx == ex_rd_idx));

  // Stage controls from current state and this cycle's hazards (memory wait wins).
  always_comb begin
    front     = 1'b0;
    exec_hold = 1'b0;
    bubble    = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          front     = 1'b1;
          exec_hold = 1'b1;
        end else if (load_use) begin
          front  = 1'b1;
          bubble = 1'b1;
        end
      end
      LOAD_BUBBLE: begin
        if (mem_wait) begin
          front     = 1'b1;
          exec_hold = 1'b1;
        end else begin
          front  = 1'b1;
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          front     = 1'b1;
          exec_hold = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Gated by rst_n so the stages are released the moment reset asserts.
  assign stall_front = rst_n && front;
  assign stall_exec  = rst_n && exec_hold;
  assign bubble_exec = rst_n && bubble;
  assign fwd_rs1_sel = rst_n ? rs1_sel : FWD_REG;
  assign fwd_rs2_sel = rst_n ? rs2_sel : FWD_REG;

  pipeline_stall_ctrl_fwd_select u_fwd_rs1 (
    .src_idx              (dec_rs1_idx),
    .ex_rd_idx            (ex_rd_idx),
    .ex_reg_write_enable  (ex_reg_write_enable),
    .ex_mem_load_enable   (ex_mem_load_enable),
    .mem_rd_idx           (mem_rd_idx),
    .mem_reg_write_enable (mem_reg_write_enable),
    .sel                  (rs1_sel)
  );

  pipeline_stall_ctrl_fwd_select u_fwd_rs2 (
    .src_idx              (dec_rs2_idx),
    .ex_rd_idx            (ex_rd_idx),
    .ex_reg_write_enable  (ex_reg_write_enable),
    .ex_mem_load_enable   (ex_mem_load_enable),
    .mem_rd_idx           (mem_rd_idx),
    .mem_reg_write_enable (mem_reg_write_enable),
    .sel                  (rs2_sel)
  );

  // Scheduler FSM with bubble down-counter, saturating wait counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      bub_cnt   <= '0;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end else if (load_use && MULTI_BUBBLE) begin
            state   <= LOAD_BUBBLE;
            bub_cnt <= BUB_RELOAD;
          end
        end
        LOAD_BUBBLE: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            bub_cnt  <= '0;
            wait_cnt <= '0;
          end else begin
            bub_cnt <= bub_cnt - 2'd1;
            if (bub_cnt == 2'd1) state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt < TMO) wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt >= TMO_M1) mem_error <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Count cycles in which the front end is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (front) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench: two configurations (1 bubble / timeout 255, 3 bubbles / timeout 3)
// driven in parallel and compared against a behavioural model.
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] ex_rd; logic ex_we; logic ex_ld;
    logic [4:0] mem_rd; logic mem_we; logic macc; logic mrdy;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic u1, u2, ex_we, ex_ld, mem_we, macc, mrdy;
  logic sf[2], se[2], be[2], err[2];
  logic [1:0] f1[2], f2[2];
  logic [31:0] sc[2];

  int n_checks = 0;
  int n_fail = 0;

  int nb[2]  = '{1, 3};
  int tmo[2] = '{255, 3};

  bit          m_wait[2], nx_wait[2], m_err[2], nx_err[2];
  int          m_bub[2], nx_bub[2], m_wcnt[2], nx_wcnt[2];
  logic [31:0] m_stall[2], nx_stall[2];
  logic [7:0]  exp_o[2];
  logic [31:0] exp_sc[2];

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .dec_rs1_idx(rs1), .dec_rs2_idx(rs2), .dec_uses_rs1(u1), .dec_uses_rs2(u2),
    .ex_rd_idx(ex_rd), .ex_reg_write_enable(ex_we), .ex_mem_load_enable(ex_ld),
    .mem_rd_idx(mem_rd), .mem_reg_write_enable(mem_we),
    .mem_access(macc), .mem_ready(mrdy),
    .stall_front(sf[0]), .stall_exec(se[0]), .bubble_exec(be[0]),
    .fwd_rs1_sel(f1[0]), .fwd_rs2_sel(f2[0]),
    .mem_error(err[0]), .stall_cycles(sc[0])
  );

  pipeline_stall_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .dec_rs1_idx(rs1), .dec_rs2_idx(rs2), .dec_uses_rs1(u1), .dec_uses_rs2(u2),
    .ex_rd_idx(ex_rd), .ex_reg_write_enable(ex_we), .ex_mem_load_enable(ex_ld),
    .mem_rd_idx(mem_rd), .mem_reg_write_enable(mem_we),
    .mem_access(macc), .mem_ready(mrdy),
    .stall_front(sf[1]), .stall_exec(se[1]), .bubble_exec(be[1]),
    .fwd_rs1_sel(f1[1]), .fwd_rs2_sel(f2[1]),
    .mem_error(err[1]), .stall_cycles(sc[1])
  );

  function automatic stim_t mk(logic [4:0] a, bit ua, logic [4:0] b, bit ub,
                               logic [4:0] xr, bit xw, bit xl,
                               logic [4:0] mr, bit mw, bit ma, bit md);
    stim_t s;
    s = '{a, ua, b, ub, xr, xw, xl, mr, mw, ma, md};
    return s;
  endfunction

  function automatic logic [7:0] obs(int k);
    return {sf[k], se[k], be[k], f1[k], f2[k], err[k]};
  endfunction

  function automatic int fwd_model(logic [4:0] idx);
    if (ex_we && !ex_ld && ex_rd == idx && ex_rd != 0) return 1;
    if (mem_we && mem_rd == idx && idx != 0) return 2;
    return 0;
  endfunction

  task automatic drive(stim_t s);
    {rs1, u1, rs2, u2, ex_rd, ex_we, ex_ld, mem_rd, mem_we, macc, mrdy} = s;
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_bub[k] = 0; m_wcnt[k] = 0; m_err[k] = 0; m_stall[k] = 0;
    end
  endtask

  // Expected outputs for the current inputs, plus the model's next state.
  task automatic eval_model;
    bit hold_f, hold_x, bub, waiting, hazard;
    logic [1:0] e1, e2;
    waiting = macc && !mrdy;
    hazard  = ex_ld && ex_we && ex_rd != 0 &&
              ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
    for (int k = 0; k < 2; k++) begin
      hold_f = 0; hold_x = 0; bub = 0;
      nx_wait[k] = m_wait[k]; nx_bub[k] = m_bub[k]; nx_wcnt[k] = m_wcnt[k];
      nx_err[k] = m_err[k]; nx_stall[k] = m_stall[k];
      e1 = 2'(fwd_model(rs1));
      e2 = 2'(fwd_model(rs2));
      if (!rst_n) begin
        e1 = 0; e2 = 0;
        nx_wait[k] = 0; nx_bub[k] = 0; nx_wcnt[k] = 0; nx_err[k] = 0; nx_stall[k] = 0;
        exp_o[k] = 8'd0;
        exp_sc[k] = 32'd0;
      end else begin
        if (m_wait[k]) begin
          if (mrdy) begin
            nx_wait[k] = 0; nx_wcnt[k] = 0;
          end else begin
            hold_f = 1; hold_x = 1;
            nx_wcnt[k] = (m_wcnt[k] + 1 > tmo[k]) ? tmo[k] : m_wcnt[k] + 1;
            if (nx_wcnt[k] >= tmo[k]) nx_err[k] = 1;
          end
        end else if (waiting) begin
          hold_f = 1; hold_x = 1; nx_wait[k] = 1; nx_wcnt[k] = 0; nx_bub[k] = 0;
        end else if (m_bub[k] > 0) begin
          hold_f = 1; bub = 1; nx_bub[k] = m_bub[k] - 1;
        end else if (hazard) begin
          hold_f = 1; bub = 1; nx_bub[k] = nb[k] - 1;
        end
        if (hold_f) nx_stall[k] = m_stall[k] + 32'd1;
        exp_o[k]  = {hold_f, hold_x, bub, e1, e2, m_err[k]};
        exp_sc[k] = m_stall[k];
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = nx_wait[k]; m_bub[k] = nx_bub[k]; m_wcnt[k] = nx_wcnt[k];
      m_err[k] = nx_err[k]; m_stall[k] = nx_stall[k];
    end
    @(negedge clk);
  endtask

  task automatic apply_reset;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    drive(mk(5, 1, 0, 0, 5, 1, 1, 5, 1, 1, 0));
    #1;
    eval_model();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs(k) !== 8'd0 || sc[k] !== 32'd0 || obs(k) !== exp_o[k]) begin
        n_fail++;
        $display("FAIL reset dut%0d: got out=%b cnt=%0d, want out=%b cnt=0", k, obs(k), sc[k], exp_o[k]);
      end
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use;
    stim_t t[$];
    apply_reset();
    t.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1));
    t.push_back(mk(5, 1, 0, 0, 0, 0, 0, 5, 1, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
          n_fail++;
          $display("FAIL load_use step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      if (i == 0) begin
        n_checks++;
        if (!(sf[0] === 1'b1 && be[0] === 1'b1 && se[0] === 1'b0)) begin
          n_fail++;
          $display("FAIL load_use_bubble: got front=%b bubble=%b exec=%b, want 1 1 0", sf[0], be[0], se[0]);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (f1[0] !== 2'd2 || sf[0] !== 1'b0 || sc[0] !== 32'd1) begin
          n_fail++;
          $display("FAIL load_use_fwd: got fwd1=%0d front=%b cnt=%0d, want 2 0 1", f1[0], sf[0], sc[0]);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (sc[1] !== 32'd3 || sf[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL load_use_3bubbles: got cnt=%0d front=%b, want 3 0", sc[1], sf[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_forward;
    stim_t t[$];
    apply_reset();
    t.push_back(mk(0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    t.push_back(mk(3, 1, 3, 1, 3, 1, 0, 3, 1, 0, 1));
    t.push_back(mk(3, 1, 9, 1, 8, 1, 1, 3, 1, 0, 1));
    t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
          n_fail++;
          $display("FAIL forward step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      if (i == 0) begin
        n_checks++;
        if (f2[0] !== 2'd1 || sf[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL fwd_ex_rs2: got sel=%0d front=%b, want 1 0", f2[0], sf[0]);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (f2[0] !== 2'd0) begin
          n_fail++;
          $display("FAIL fwd_x0: got sel=%0d, want 0", f2[0]);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (f1[0] !== 2'd1 || f2[0] !== 2'd1) begin
          n_fail++;
          $display("FAIL fwd_newest: got sel1=%0d sel2=%0d, want 1 1", f1[0], f2[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_mem_wait;
    stim_t t[$];
    apply_reset();
    repeat (4) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
          n_fail++;
          $display("FAIL mem_wait step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      if (i < 4) begin
        n_checks++;
        if (sf[0] !== 1'b1 || se[0] !== 1'b1 || be[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_wait_hold step %0d: got front=%b exec=%b bubble=%b, want 1 1 0", i, sf[0], se[0], be[0]);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (sf[0] !== 1'b0 || se[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_wait_release: got front=%b exec=%b, want 0 0", sf[0], se[0]);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (sc[0] !== 32'd4 || err[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_wait_count: got cnt=%0d err=%b, want 4 0", sc[0], err[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout;
    stim_t t[$];
    apply_reset();
    repeat (6) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    repeat (2) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
          n_fail++;
          $display("FAIL timeout step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (err[1] !== 1'b1 || err[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_sticky: got err_b=%b err_a=%b, want 1 0", err[1], err[0]);
        end
      end
      tick();
    end
    apply_reset();
    #1;
    n_checks++;
    if (err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got err=%b, want 0", err[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_hazard_and_wait;
    stim_t t[$];
    apply_reset();
    repeat (3) t.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0));
    t.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 1, 1));
    t.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
          n_fail++;
          $display("FAIL hazard_wait step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      if (i < 3) begin
        n_checks++;
        if (be[0] !== 1'b0 || se[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL hazard_wait_prio step %0d: got bubble=%b exec=%b, want 0 1", i, be[0], se[0]);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (be[0] !== 1'b1 || sf[0] !== 1'b1 || se[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL hazard_after_wait: got bubble=%b front=%b exec=%b, want 1 1 0", be[0], sf[0], se[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait;
    stim_t w;
    w = mk(2, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(w);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
          n_fail++;
          $display("FAIL reset_mid step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      tick();
    end
    drive(w);
    #2;
    rst_n = 1'b0;
    #1;
    eval_model();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs(k) !== 8'd0 || sc[k] !== 32'd0 || obs(k) !== exp_o[k]) begin
        n_fail++;
        $display("FAIL reset_mid_async dut%0d: got out=%b cnt=%0d, want out=0 cnt=0", k, obs(k), sc[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    drive(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1));
    #1;
    eval_model();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k]) begin
        n_fail++;
        $display("FAIL reset_mid_release dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs(k), sc[k], exp_o[k], exp_sc[k]);
      end
    end
    n_checks++;
    if (sf[0] !== 1'b1 || be[0] !== 1'b1 || se[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got front=%b bubble=%b exec=%b, want 1 1 0", sf[0], be[0], se[0]);
    end
    tick();
  endtask

  task automatic test_random;
    stim_t s;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      s = mk(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      drive(s);
      #1;
      eval_model();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_o[k] || sc[k] !== exp_sc[k] || err[k] !== m_err[k]) begin
          n_fail++;
          $display("FAIL random step %0d dut%0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, k, obs(k), sc[k], exp_o[k], exp_sc[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_forward();
    test_mem_wait();
    test_timeout();
    test_hazard_and_wait();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
